// File: rtl/parity_pkg.sv
// Shared types and helpers for the streaming parity accumulator.
// Holds the FSM state encoding and the per-lane XOR reduction.
package parity_pkg;

    typedef enum logic {ACCUM, DONE} parity_state_t;

    localparam int unsigned MAX_LANE_W = 64;

    // XOR-reduce the low lane_w bits of data; upper bits are ignored.
    function automatic logic lane_parity(
        input logic [MAX_LANE_W-1:0] data,
        input int unsigned           lane_w
    );
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < MAX_LANE_W; i++) begin
            if (i < lane_w) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/parity_lane.sv
// Combinational parity reducer for one LANE_W-bit lane.
// Ports: data (lane bits in), parity (XOR of all lane bits out).
module parity_lane
    import parity_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0] data,
    output logic              parity
);

    if (LANE_W > MAX_LANE_W) begin : g_bad_w
        $error("parity_lane: LANE_W exceeds MAX_LANE_W");
    end

    assign parity = lane_parity(MAX_LANE_W'(data), LANE_W);

endmodule

// File: rtl/parity_accumulator.sv
// Per-packet column parity engine over a valid/ready beat stream.
// Ports: clock/reset, in_valid/in_ready/in_data/in_last beat input,
// pkt_valid/pkt_ready with pkt_lane_parity, pkt_parity, pkt_beats.
module parity_accumulator
    import parity_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter bit ODD    = 1'b0,
    parameter int CNT_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    output logic                     pkt_valid,
    input  logic                     pkt_ready,
    output logic [DATA_W/LANE_W-1:0] pkt_lane_parity,
    output logic                     pkt_parity,
    output logic [CNT_W-1:0]         pkt_beats
);

    localparam int LANES = DATA_W / LANE_W;

    if (DATA_W % LANE_W != 0) begin : g_bad_div
        $error("parity_accumulator: DATA_W must be a multiple of LANE_W");
    end

    parity_state_t    state, state_nx;
    logic [LANES-1:0] acc, acc_nx, raw;
    logic [CNT_W-1:0] beats, beats_nx;
    logic             take;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        parity_lane #(.LANE_W(LANE_W)) u_lane (
            .data   (in_data[k*LANE_W +: LANE_W]),
            .parity (raw[k])
        );
    end

    // Gated by reset so a beat presented during reset is never consumed.
    assign in_ready = (state == ACCUM) && !reset;
    assign take     = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        beats_nx = beats;
        unique case (state)
            ACCUM: begin
                if (take) begin
                    acc_nx = acc ^ raw;
                    // Saturate rather than wrap; parity keeps accumulating.
                    if (beats != {CNT_W{1'b1}}) begin
                        beats_nx = beats + 1'b1;
                    end
                    if (in_last) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (pkt_ready) begin
                    acc_nx   = '0;
                    beats_nx = '0;
                    state_nx = ACCUM;
                end
            end
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ACCUM;
            acc   <= '0;
            beats <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            beats <= beats_nx;
        end
    end

    assign pkt_valid       = (state == DONE);
    assign pkt_lane_parity = acc ^ {LANES{ODD}};
    assign pkt_parity      = (^acc) ^ ODD;
    assign pkt_beats       = beats;

endmodule

// File: tb/tb_parity_accumulator.sv
// Directed bench for parity_accumulator: three parameterisations
// share one stimulus stream (default, ODD=1, CNT_W=2).
module tb_parity_accumulator;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        pkt_ready;

    logic        a_ready, a_valid, a_par;
    logic [3:0]  a_lane;
    logic [15:0] a_beats;

    logic        b_ready, b_valid, b_par;
    logic [3:0]  b_lane;
    logic [15:0] b_beats;

    logic        c_ready, c_valid, c_par;
    logic [3:0]  c_lane;
    logic [1:0]  c_beats;

    int checks = 0;
    int errors = 0;

    parity_accumulator u_a (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(a_ready),
        .in_data(in_data), .in_last(in_last),
        .pkt_valid(a_valid), .pkt_ready(pkt_ready),
        .pkt_lane_parity(a_lane), .pkt_parity(a_par),
        .pkt_beats(a_beats)
    );

    parity_accumulator #(.ODD(1'b1)) u_b (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(b_ready),
        .in_data(in_data), .in_last(in_last),
        .pkt_valid(b_valid), .pkt_ready(pkt_ready),
        .pkt_lane_parity(b_lane), .pkt_parity(b_par),
        .pkt_beats(b_beats)
    );

    parity_accumulator #(.CNT_W(2)) u_c (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(c_ready),
        .in_data(in_data), .in_last(in_last),
        .pkt_valid(c_valid), .pkt_ready(pkt_ready),
        .pkt_lane_parity(c_lane), .pkt_parity(c_par),
        .pkt_beats(c_beats)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_pkt();
        pkt_ready = 1'b1;
        step();
        pkt_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        in_last   = 1'b1;
        pkt_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(a_ready), 32'h0);
        chk("rst_valid", 32'(a_valid), 32'h0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        reset    = 1'b0;
        step();
        chk("idle_ready", 32'(a_ready), 32'h1);
        chk("idle_valid", 32'(a_valid), 32'h0);
        chk("idle_beats", 32'(a_beats), 32'h0);
        chk("idle_lane", 32'(a_lane), 32'h0);
        chk("idle_par", 32'(a_par), 32'h0);
        chk("idle_lane_odd", 32'(b_lane), 32'hF);
        chk("idle_par_odd", 32'(b_par), 32'h1);

        // single beat 0x1
        beat(32'h0000_0001, 1'b1);
        chk("t1_valid", 32'(a_valid), 32'h1);
        chk("t1_lane", 32'(a_lane), 32'h1);
        chk("t1_par", 32'(a_par), 32'h1);
        chk("t1_beats", 32'(a_beats), 32'h1);
        chk("t1_ready", 32'(a_ready), 32'h0);
        chk("t1_lane_odd", 32'(b_lane), 32'hE);
        chk("t1_par_odd", 32'(b_par), 32'h0);
        release_pkt();
        chk("t1_rel_valid", 32'(a_valid), 32'h0);
        chk("t1_rel_ready", 32'(a_ready), 32'h1);
        chk("t1_rel_beats", 32'(a_beats), 32'h0);

        // two beats
        beat(32'h0101_0101, 1'b0);
        chk("t2_mid_valid", 32'(a_valid), 32'h0);
        chk("t2_mid_beats", 32'(a_beats), 32'h1);
        chk("t2_mid_ready", 32'(a_ready), 32'h1);
        beat(32'h0100_0000, 1'b1);
        chk("t2_valid", 32'(a_valid), 32'h1);
        chk("t2_lane", 32'(a_lane), 32'h7);
        chk("t2_par", 32'(a_par), 32'h1);
        chk("t2_beats", 32'(a_beats), 32'h2);
        chk("t2_ready", 32'(a_ready), 32'h0);

        // back-pressure with in_valid asserted
        in_valid = 1'b1;
        in_data  = 32'h0000_00FE;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_valid", 32'(a_valid), 32'h1);
            chk("t3_lane", 32'(a_lane), 32'h7);
            chk("t3_beats", 32'(a_beats), 32'h2);
            chk("t3_ready", 32'(a_ready), 32'h0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        release_pkt();
        chk("t3_rel_ready", 32'(a_ready), 32'h1);
        chk("t3_rel_valid", 32'(a_valid), 32'h0);
        chk("t3_rel_lane", 32'(a_lane), 32'h0);

        // zero beat: odd instance inverts everything
        beat(32'h0000_0000, 1'b1);
        chk("t4_lane_odd", 32'(b_lane), 32'hF);
        chk("t4_par_odd", 32'(b_par), 32'h1);
        chk("t4_beats_odd", 32'(b_beats), 32'h1);
        chk("t4_lane_even", 32'(a_lane), 32'h0);
        chk("t4_par_even", 32'(a_par), 32'h0);
        release_pkt();

        // abort a partial packet with reset
        beat(32'hFF00_FF01, 1'b0);
        beat(32'h0000_0003, 1'b0);
        chk("t5_part_beats", 32'(a_beats), 32'h2);
        chk("t5_part_lane", 32'(a_lane), 32'h1);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        step();
        chk("t5_rst_ready", 32'(a_ready), 32'h0);
        chk("t5_rst_beats", 32'(a_beats), 32'h0);
        chk("t5_rst_valid", 32'(a_valid), 32'h0);
        reset    = 1'b0;
        in_valid = 1'b0;
        beat(32'h0000_0007, 1'b1);
        chk("t5_valid", 32'(a_valid), 32'h1);
        chk("t5_lane", 32'(a_lane), 32'h1);
        chk("t5_par", 32'(a_par), 32'h1);
        chk("t5_beats", 32'(a_beats), 32'h1);
        release_pkt();

        // saturation on CNT_W=2, with an idle gap mid-packet
        beat(32'h0000_0001, 1'b0);
        beat(32'h0000_0001, 1'b0);
        step();
        chk("t6_gap_beats", 32'(c_beats), 32'h2);
        beat(32'h0000_0001, 1'b0);
        beat(32'h0000_0001, 1'b0);
        chk("t6_sat_beats", 32'(c_beats), 32'h3);
        chk("t6_sat_lane", 32'(c_lane), 32'h0);
        beat(32'h0000_0001, 1'b1);
        chk("t6_valid", 32'(c_valid), 32'h1);
        chk("t6_beats", 32'(c_beats), 32'h3);
        chk("t6_lane", 32'(c_lane), 32'h1);
        chk("t6_par", 32'(c_par), 32'h1);
        chk("t6_beats_wide", 32'(a_beats), 32'h5);
        release_pkt();
        chk("t6_rel_beats", 32'(c_beats), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
